// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide datapath: drives the product/remainder
// register controls, counts iterations and flags completion and divide-by-zero.
module multdiv_ctrl #(
   parameter int ITERS = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic             divisor_zero,
   output logic             reg_en,
   output logic             load_sel,
   output logic             reg_out_en,
   output logic             op_div,
   output logic [CNT_W-1:0] step_count,
   output logic             busy,
   output logic             data_resultRDY,
   output logic             data_exception
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERS - 1);

   state_t state_reg, state_next;
   logic   exc_reg;
   logic   held_reg;
   logic   start;
   logic   start_div;

   // A start request wins over whatever is in flight; multiply wins a tie.
   assign start     = ctrl_MULT | ctrl_DIV;
   assign start_div = ctrl_DIV & ~ctrl_MULT;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: state_next = IDLE;
         LOAD: state_next = exc_reg ? DONE : RUN;
         RUN:  state_next = (step_count == LAST_STEP) ? DONE : RUN;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (start) begin
         state_next = LOAD;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg      <= IDLE;
         step_count     <= '0;
         op_div         <= 1'b0;
         exc_reg        <= 1'b0;
         data_exception <= 1'b0;
         held_reg       <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (start) begin
            step_count     <= '0;
            op_div         <= start_div;
            exc_reg        <= start_div & divisor_zero;
            data_exception <= 1'b0;
            held_reg       <= 1'b0;
         end else begin
            if (state_reg == RUN && step_count != LAST_STEP) begin
               step_count <= step_count + 1'b1;
            end
            if (state_next == DONE) begin
               data_exception <= exc_reg;
            end
            // Keep driving the bus after completion until a new op or reset.
            if (state_reg == DONE) begin
               held_reg <= 1'b1;
            end
         end
      end
   end

   assign reg_en         = (state_reg == LOAD) || (state_reg == RUN);
   assign busy           = (state_reg == LOAD) || (state_reg == RUN);
   assign load_sel       = (state_reg == LOAD);
   assign data_resultRDY = (state_reg == DONE);
   assign reg_out_en     = (state_reg == DONE) || ((state_reg == IDLE) && held_reg);

endmodule
